// File: rtl/me_pkg.sv
// Shared widths and FSM state type for the motion-estimation search controller.
package me_pkg;

    localparam int unsigned SAD_W      = 13;
    localparam int unsigned MADDR_W    = 8;
    localparam int unsigned MRES_W     = 21;
    localparam int unsigned CAND_IDX_W = 6;

    localparam logic [SAD_W-1:0] SAD_INIT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } me_state_t;

endpackage

// File: rtl/me_search_ctrl_if.sv
// Control/result bundle between the search controller (slave) and its driver (master).
interface me_search_ctrl_if import me_pkg::*; ();

    logic                  start;
    logic                  abort;
    logic [MRES_W-1:0]     mad_res;
    logic [CAND_IDX_W-1:0] sr_addressRead;
    logic                  load_en;
    logic                  busy;
    logic                  done;
    logic [SAD_W-1:0]      best_sad;
    logic [MADDR_W-1:0]    best_addr;

    modport master (
        output start, abort, mad_res,
        input  sr_addressRead, load_en, busy, done, best_sad, best_addr
    );

    modport slave (
        input  start, abort, mad_res,
        output sr_addressRead, load_en, busy, done, best_sad, best_addr
    );

endinterface

// File: rtl/me_valid_dly.sv
// PIPE_LAT-deep valid-tag delay line with synchronous clear; bit LAT-1 is the output.
module me_valid_dly #(
    parameter int unsigned LAT = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_din,
    output logic o_out,
    output logic o_any
);

    localparam logic [LAT-1:0] OUT_MSK = LAT'(1) << (LAT - 1);

    logic [LAT-1:0] r_sh;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_sh <= '0;
        end else begin
            r_sh <= (r_sh << 1) | LAT'(i_din);
        end
    end

    assign o_out = r_sh[LAT-1];
    // Any tag still behind the output: the line is non-empty after this shift.
    assign o_any = |(r_sh & ~OUT_MSK);

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search candidate sequencer: issues row groups to the MAD datapath and
// tracks the minimum SAD (earliest candidate wins ties) from tagged results.
module me_search_ctrl import me_pkg::*; #(
    parameter int unsigned NUM_CAND      = 64,
    parameter int unsigned ROWS_PER_CAND = 4,
    parameter int unsigned PIPE_LAT      = 6
) (
    input  logic           clk,
    input  logic           rst,
    me_search_ctrl_if.slave bus
);

    localparam int unsigned PH_W = (ROWS_PER_CAND > 1) ? $clog2(ROWS_PER_CAND) : 1;
    localparam logic [PH_W-1:0]       PH_LAST   = PH_W'(ROWS_PER_CAND - 1);
    localparam logic [CAND_IDX_W-1:0] CAND_LAST = CAND_IDX_W'(NUM_CAND - 1);

    me_state_t             r_state;
    logic [PH_W-1:0]       r_phase;
    logic [CAND_IDX_W-1:0] r_cand;
    logic [6:0]            r_res_cnt;
    logic                  r_load_en;
    logic                  r_busy;
    logic                  r_done;
    logic [SAD_W-1:0]      r_best_sad;
    logic [MADDR_W-1:0]    r_best_addr;

    logic                  w_last_phase;
    logic                  w_abort;
    logic                  w_tag;
    logic                  w_any;
    logic                  w_take;
    logic [SAD_W-1:0]      w_sad;
    logic [MADDR_W-1:0]    w_maddr;

    assign w_last_phase = (r_state == ST_ISSUE) && (r_phase == PH_LAST);
    assign w_abort      = bus.abort && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_sad        = bus.mad_res[MRES_W-1:MADDR_W];
    assign w_maddr      = bus.mad_res[MADDR_W-1:0];
    assign w_take       = w_tag && ((r_res_cnt == '0) || (w_sad < r_best_sad));

    me_valid_dly #(
        .LAT(PIPE_LAT)
    ) u_valid_dly (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_abort),
        .i_din (w_last_phase),
        .o_out (w_tag),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_cand      <= '0;
            r_res_cnt   <= '0;
            r_load_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_best_sad  <= SAD_INIT;
            r_best_addr <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_ISSUE;
                        r_phase     <= '0;
                        r_cand      <= '0;
                        r_res_cnt   <= '0;
                        r_load_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_best_sad  <= SAD_INIT;
                        r_best_addr <= '0;
                    end
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (bus.abort) begin
                        r_state     <= ST_IDLE;
                        r_res_cnt   <= '0;
                        r_load_en   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_best_sad  <= SAD_INIT;
                        r_best_addr <= '0;
                    end else begin
                        if (w_tag) begin
                            r_res_cnt <= r_res_cnt + 7'd1;
                        end
                        if (w_take) begin
                            r_best_sad  <= w_sad;
                            r_best_addr <= w_maddr;
                        end
                        if (r_state == ST_ISSUE) begin
                            if (r_phase == PH_LAST) begin
                                r_phase <= '0;
                                if (r_cand == CAND_LAST) begin
                                    r_state   <= ST_DRAIN;
                                    r_load_en <= 1'b0;
                                end else begin
                                    r_cand <= r_cand + 1'b1;
                                end
                            end else begin
                                r_phase <= r_phase + 1'b1;
                            end
                        end else if (!w_any) begin
                            // Last tag is at the output now; its result lands this edge.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sr_addressRead = r_cand;
    assign bus.load_en        = r_load_en;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.best_sad       = r_best_sad;
    assign bus.best_addr      = r_best_addr;

endmodule
